// File: rtl/motor_ramp_controller_if.sv
// Command channel into the motor ramp controller: valid/ready with target velocity and step size.
interface motor_ramp_controller_if;
  logic              cmd_valid;
  logic              cmd_ready;
  logic signed [7:0] cmd_target;
  logic        [3:0] cmd_step;

  modport master (output cmd_valid, output cmd_target, output cmd_step, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_target, input cmd_step, output cmd_ready);
endinterface

// File: rtl/motor_ramp_controller.sv
// Steps a signed 8-bit velocity toward commanded targets on a prescaled tick,
// passing through a zero dwell on reversal; estop forces zero immediately.
module motor_ramp_controller #(
  parameter int TICK_DIV    = 1000,
  parameter int DWELL_TICKS = 4
) (
  input  logic                     cclk,
  input  logic                     rst,
  motor_ramp_controller_if.slave   cmd,
  input  logic                     estop,
  output logic signed [7:0]        velocity,
  output logic                     busy,
  output logic                     at_target
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [7:0]    DWELL_LAST = 8'(DWELL_TICKS - 1);

  typedef enum logic [1:0] {IDLE, RAMP, DWELL, STOP} state_t;

  state_t            state_q;
  logic [PW-1:0]     presc_q;
  logic [7:0]        dwell_q;
  logic signed [7:0] vel_q;
  logic signed [7:0] tgt_q;
  logic [3:0]        step_q;
  logic              at_target_q;

  logic              tick_d;
  logic              opp_d;
  logic signed [7:0] goal_d;
  logic signed [7:0] vel_d;

  // Target 0 is never opposing, so a ramp to zero never enters the dwell.
  function automatic logic opposing(input logic signed [7:0] cur, input logic signed [7:0] tgt);
    return (cur != 8'sd0) && (tgt != 8'sd0) && (cur[7] != tgt[7]);
  endfunction

  // 9-bit arithmetic; clamps onto the goal so neither end of the range can wrap.
  function automatic logic signed [7:0] step_toward(input logic signed [7:0] cur,
                                                    input logic signed [7:0] goal,
                                                    input logic [3:0]        step);
    logic signed [8:0] cur9;
    logic signed [8:0] diff;
    logic signed [8:0] stp;
    logic signed [8:0] nxt;
    logic        [8:0] mag;
    cur9 = {cur[7], cur};
    diff = {goal[7], goal} - cur9;
    mag  = diff[8] ? 9'(-diff) : 9'(diff);
    stp  = {5'b0, step};
    if (mag <= 9'(step)) return goal;
    nxt = diff[8] ? (cur9 - stp) : (cur9 + stp);
    return nxt[7:0];
  endfunction

  assign tick_d = (presc_q == TICK_LAST);
  assign opp_d  = opposing(vel_q, tgt_q);
  assign goal_d = opp_d ? 8'sd0 : tgt_q;
  assign vel_d  = step_toward(vel_q, goal_d, step_q);

  assign cmd.cmd_ready = (state_q == IDLE) && !estop;
  assign velocity      = vel_q;
  assign busy          = (state_q != IDLE);
  assign at_target     = at_target_q;

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      dwell_q     <= '0;
      vel_q       <= '0;
      tgt_q       <= '0;
      step_q      <= 4'd1;
      at_target_q <= 1'b0;
    end else begin
      presc_q     <= tick_d ? '0 : presc_q + PW'(1);
      at_target_q <= 1'b0;
      if (estop) begin
        state_q <= STOP;
        vel_q   <= '0;
        dwell_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cmd.cmd_valid) begin
              tgt_q  <= cmd.cmd_target;
              step_q <= (cmd.cmd_step == 4'd0) ? 4'd1 : cmd.cmd_step;
              if (cmd.cmd_target == vel_q) at_target_q <= 1'b1;
              else                         state_q     <= RAMP;
            end
          end
          RAMP: begin
            if (tick_d) begin
              vel_q <= vel_d;
              if (vel_d == tgt_q) begin
                state_q     <= IDLE;
                at_target_q <= 1'b1;
              end else if ((vel_d == 8'sd0) && opp_d && (DWELL_TICKS > 0)) begin
                state_q <= DWELL;
                dwell_q <= '0;
              end
            end
          end
          // Leaves on the last dwell tick so the next tick already steps past zero.
          DWELL: begin
            if (tick_d) begin
              if (dwell_q == DWELL_LAST) begin
                state_q <= RAMP;
                dwell_q <= '0;
              end else begin
                dwell_q <= dwell_q + 8'd1;
              end
            end
          end
          STOP:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motor_ramp_controller.sv
// Directed bench for motor_ramp_controller with a velocity-change scoreboard.
module tb_motor_ramp_controller;
  localparam int TD = 4;
  localparam int DW = 2;

  logic              cclk = 1'b0;
  logic              rst = 1'b1;
  logic              estop = 1'b0;
  logic signed [7:0] velocity;
  logic              busy;
  logic              at_target;

  motor_ramp_controller_if cmd_if();

  motor_ramp_controller #(.TICK_DIV(TD), .DWELL_TICKS(DW)) dut (
    .cclk      (cclk),
    .rst       (rst),
    .cmd       (cmd_if),
    .estop     (estop),
    .velocity  (velocity),
    .busy      (busy),
    .at_target (at_target)
  );

  always #5 cclk = ~cclk;

  typedef struct {
    logic signed [7:0] vel;
    int                gap;
  } exp_t;

  exp_t              exp_q[$];
  int                tests = 0;
  int                fails = 0;
  int                at_cnt = 0;
  int                cyc = 0;
  int                last_chg = 0;
  logic signed [7:0] prev_vel = 8'sd0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic signed [7:0] v, input int g);
    exp_t e;
    e.vel = v;
    e.gap = g;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge cclk);
    cyc++;
  end

  // Scoreboard: every velocity change must match the next queued value and tick spacing.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge cclk);
      if (rst) begin
        prev_vel = velocity;
      end else begin
        if (at_target === 1'b1) begin
          at_cnt++;
          check("busy_low_with_at_target", busy, 0);
        end
        if (velocity !== prev_vel) begin
          if (exp_q.size() == 0) begin
            check("unexpected_velocity_change", velocity, prev_vel);
          end else begin
            e = exp_q.pop_front();
            check("velocity", velocity, e.vel);
            if (e.gap != 0) check("tick_spacing", cyc - last_chg, e.gap);
          end
          last_chg = cyc;
          prev_vel = velocity;
        end
      end
    end
  end

  task automatic send(input logic signed [7:0] t, input logic [3:0] s);
    int n = 0;
    @(negedge cclk);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = t;
    cmd_if.cmd_step   = s;
    #1;
    while (!cmd_if.cmd_ready && n < 200) begin
      @(negedge cclk);
      #1;
      n++;
    end
    check("accept_wait", (n < 200), 1);
    @(posedge cclk);
    @(negedge cclk);
    cmd_if.cmd_valid = 1'b0;
    #1;
  endtask

  task automatic wait_done(input string tag, input int start);
    int n = 0;
    while (at_cnt == start && n < 400) begin
      @(negedge cclk);
      #1;
      n++;
    end
    check({tag, "_done"}, at_cnt, start + 1);
    repeat (3) @(negedge cclk);
    #1;
    check({tag, "_single_pulse"}, at_cnt, start + 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic wait_vel(input logic signed [7:0] v);
    int n = 0;
    while (velocity !== v && n < 200) begin
      @(negedge cclk);
      #1;
      n++;
    end
    check("wait_velocity", velocity, v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int ready_hi;
    int n;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_target = 8'sd0;
    cmd_if.cmd_step   = 4'd0;

    repeat (3) @(negedge cclk);
    #1;
    check("reset_velocity", velocity, 0);
    check("reset_busy", busy, 0);
    check("reset_at_target", at_target, 0);
    check("reset_cmd_ready", cmd_if.cmd_ready, 1);
    @(negedge cclk);
    #1;
    rst = 1'b0;

    // ramp up
    s = at_cnt;
    push(8'sd3, 0); push(8'sd6, 4); push(8'sd9, 4); push(8'sd10, 4);
    send(8'sd10, 4'd3);
    check("rampup_busy", busy, 1);
    wait_done("rampup", s);

    // reversal through zero with dwell
    s = at_cnt;
    push(8'sd6, 0); push(8'sd2, 4); push(8'sd0, 4); push(-8'sd4, 12); push(-8'sd5, 4);
    send(-8'sd5, 4'd4);
    wait_done("reversal", s);

    s = at_cnt;
    push(8'sd0, 0);
    send(8'sd0, 4'd15);
    wait_done("to_zero", s);

    // extremes
    s = at_cnt;
    for (int k = 1; k <= 8; k++) push(8'(15 * k), (k == 1) ? 0 : 4);
    push(8'sd127, 4);
    send(8'sd127, 4'd15);
    wait_done("to_max", s);
    check("vel_max", velocity, 127);

    s = at_cnt;
    for (int k = 1; k <= 8; k++) push(8'(127 - 15 * k), (k == 1) ? 0 : 4);
    push(8'sd0, 4);
    for (int k = 1; k <= 8; k++) push(8'(-15 * k), (k == 1) ? 12 : 4);
    push(-8'sd128, 4);
    send(-8'sd128, 4'd15);
    wait_done("to_min", s);
    check("vel_min", velocity, -128);

    s = at_cnt;
    push(-8'sd127, 0); push(-8'sd126, 4);
    send(-8'sd126, 4'd0);
    wait_done("step_zero", s);

    s = at_cnt;
    for (int k = 1; k <= 8; k++) push(8'(-126 + 15 * k), (k == 1) ? 0 : 4);
    push(8'sd0, 4);
    send(8'sd0, 4'd15);
    wait_done("back_to_zero", s);

    // asynchronous reset mid-ramp
    s = at_cnt;
    push(8'sd3, 0); push(8'sd6, 4); push(8'sd9, 4);
    send(8'sd20, 4'd3);
    wait_vel(8'sd9);
    rst = 1'b1;
    #1;
    check("midreset_velocity", velocity, 0);
    check("midreset_busy", busy, 0);
    check("midreset_at_target", at_target, 0);
    check("midreset_cmd_ready", cmd_if.cmd_ready, 1);
    exp_q.delete();
    @(negedge cclk);
    #1;
    rst = 1'b0;
    check("midreset_no_pulse", at_cnt, s);

    // emergency stop
    s = at_cnt;
    push(8'sd3, 0); push(8'sd6, 4); push(8'sd0, 0);
    send(8'sd20, 4'd3);
    wait_vel(8'sd6);
    estop = 1'b1;
    @(negedge cclk);
    #1;
    check("estop_velocity", velocity, 0);
    check("estop_cmd_ready", cmd_if.cmd_ready, 0);
    check("estop_busy", busy, 1);
    estop = 1'b0;
    @(negedge cclk);
    #1;
    check("release_busy", busy, 0);
    check("release_velocity", velocity, 0);
    check("release_cmd_ready", cmd_if.cmd_ready, 1);
    check("release_no_pulse", at_cnt, s);

    // trivial command accepted right after release
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 8'sd0;
    cmd_if.cmd_step   = 4'd0;
    @(posedge cclk);
    @(negedge cclk);
    cmd_if.cmd_valid = 1'b0;
    #1;
    check("trivial_at_target", at_cnt, s + 1);
    check("trivial_busy", busy, 0);
    check("trivial_velocity", velocity, 0);

    // command held through an active ramp, accepted back-to-back with at_target
    s = at_cnt;
    push(8'sd4, 0); push(8'sd8, 4); push(8'sd7, 4); push(8'sd6, 4); push(8'sd5, 4);
    send(8'sd8, 4'd4);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 8'sd5;
    cmd_if.cmd_step   = 4'd1;
    #1;
    check("hold_busy", busy, 1);
    ready_hi = 0;
    n = 0;
    while (at_cnt == s && n < 200) begin
      if (cmd_if.cmd_ready) ready_hi++;
      @(negedge cclk);
      #1;
      n++;
    end
    check("hold_ready_low_during_ramp", ready_hi, 0);
    check("hold_first_done", at_cnt, s + 1);
    check("hold_ready_at_completion", cmd_if.cmd_ready, 1);
    @(negedge cclk);
    cmd_if.cmd_valid = 1'b0;
    #1;
    check("back_to_back_accept", busy, 1);
    wait_done("handshake", s + 1);

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
